// File: rtl/anc_pkg.sv
// ---------------------------------------------------------------------------
// anc_pkg
// Shared widths, sample/product types and saturation limits for the ANC core.
// Imported by the adaptation datapath and reusable by the FIR accumulator.
// ---------------------------------------------------------------------------
package anc_pkg;

  localparam int ANC_DW           = 11;
  localparam int ANC_MU_SHIFT_DEF = 4;

  typedef logic signed [ANC_DW-1:0]   sample_t;
  typedef logic signed [2*ANC_DW-1:0] prod_t;

  localparam sample_t SAT_MAX = sample_t'(2**(ANC_DW-1) - 1);
  localparam sample_t SAT_MIN = sample_t'(-(2**(ANC_DW-1)));

endpackage

// File: rtl/anc_adapt_if.sv
// ---------------------------------------------------------------------------
// anc_adapt_if
// Sample/coefficient bus of the LMS weight-update block.
//   FilterEN : adaptation enable (sample strobe)
//   Err      : signed error-microphone sample
//   SigIn    : signed reference-signal sample
//   WzIn     : signed current coefficient
//   WzOut    : signed updated coefficient (registered in the block)
// master = sample source / coefficient store, slave = anc_adapt.
// ---------------------------------------------------------------------------
interface anc_adapt_if #(
  parameter int DW = anc_pkg::ANC_DW
);

  logic                 FilterEN;
  logic signed [DW-1:0] Err;
  logic signed [DW-1:0] SigIn;
  logic signed [DW-1:0] WzIn;
  logic signed [DW-1:0] WzOut;

  modport master (
    output FilterEN, Err, SigIn, WzIn,
    input  WzOut
  );

  modport slave (
    input  FilterEN, Err, SigIn, WzIn,
    output WzOut
  );

endinterface

// File: rtl/anc_sat_add.sv
// ---------------------------------------------------------------------------
// anc_sat_add
// Combinational saturating adder: o_sum = sat(i_a + i_b), where i_a is a
// DW-bit sample and i_b a 2*DW-bit wide term. The sum is formed in 2*DW+1
// bits so it can never wrap, then clamped to the DW-bit two's-complement
// range [-2^(DW-1), 2^(DW-1)-1].
//   i_a   : signed DW-bit operand
//   i_b   : signed 2*DW-bit operand
//   o_sum : signed DW-bit saturated result
// ---------------------------------------------------------------------------
module anc_sat_add #(
  parameter int DW = anc_pkg::ANC_DW
) (
  input  logic signed [DW-1:0]   i_a,
  input  logic signed [2*DW-1:0] i_b,
  output logic signed [DW-1:0]   o_sum
);

  localparam int SW = 2*DW + 1;
  localparam logic signed [SW-1:0] W_MAX = SW'(2**(DW-1) - 1);
  localparam logic signed [SW-1:0] W_MIN = ~W_MAX;  // -2^(DW-1)

  logic signed [SW-1:0] w_sum;

  // Size casts of signed operands sign-extend.
  assign w_sum = SW'(i_a) + SW'(i_b);

  always_comb begin
    o_sum = w_sum[DW-1:0];
    if (w_sum > W_MAX) begin
      o_sum = {1'b0, {(DW-1){1'b1}}};
    end else if (w_sum < W_MIN) begin
      o_sum = {1'b1, {(DW-1){1'b0}}};
    end
  end

endmodule

// File: rtl/anc_adapt.sv
// ---------------------------------------------------------------------------
// anc_adapt
// LMS weight-update datapath of the ANC core:
//   WzOut = sat(WzIn + ((Err * SigIn) >>> MU_SHIFT))
// Two-stage pipeline: stage 1 registers the full-precision product and the
// current coefficient when FilterEN is high; stage 2 shifts, adds and
// saturates into WzOut one edge later. One update per cycle throughput.
//
// Optional feature macro: ANC_LEAKY_EN
//   defined   -> leaky LMS: sum = w_d - (w_d >>> LEAK_SHIFT) + upd
//   undefined -> plain LMS, no leakage logic
//
// Ports:
//   Clk_100M : 100 MHz clock, rising edge
//   Reset    : asynchronous active-low reset
//   bus      : anc_adapt_if slave (FilterEN, Err, SigIn, WzIn in; WzOut out)
// ---------------------------------------------------------------------------
module anc_adapt
  import anc_pkg::*;
#(
  parameter int DW         = ANC_DW,
`ifdef ANC_LEAKY_EN
  parameter int LEAK_SHIFT = 8,
`endif
  parameter int MU_SHIFT   = ANC_MU_SHIFT_DEF
) (
  input  logic         Clk_100M,
  input  logic         Reset,
  anc_adapt_if.slave   bus
);

  // Stage 1 state
  logic signed [2*DW-1:0] r_prod;
  logic signed [DW-1:0]   r_w_d;
  logic                   r_v1;
  // Stage 2 state
  logic signed [DW-1:0]   r_wz_out;

  logic signed [2*DW-1:0] w_upd;
  logic signed [DW-1:0]   w_base;
  logic signed [DW-1:0]   w_sat;

  // Arithmetic shift on a signed operand: floor rounding toward -inf.
  assign w_upd = r_prod >>> MU_SHIFT;

`ifdef ANC_LEAKY_EN
  // Leak term only shrinks |w_d|, so the difference always fits in DW bits.
  assign w_base = r_w_d - (r_w_d >>> LEAK_SHIFT);
`else
  assign w_base = r_w_d;
`endif

  anc_sat_add #(
    .DW (DW)
  ) u_sat_add (
    .i_a   (w_base),
    .i_b   (w_upd),
    .o_sum (w_sat)
  );

  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      r_prod   <= '0;
      r_w_d    <= '0;
      r_v1     <= 1'b0;
      r_wz_out <= '0;
    end else begin
      r_v1 <= bus.FilterEN;
      if (bus.FilterEN) begin
        // 2*DW bits holds even (-2^(DW-1))^2 = +2^(2DW-2) without overflow.
        r_prod <= $signed((2*DW)'(bus.Err)) * $signed((2*DW)'(bus.SigIn));
        r_w_d  <= bus.WzIn;
      end
      if (r_v1) begin
        r_wz_out <= w_sat;
      end
    end
  end

  assign bus.WzOut = r_wz_out;

endmodule

// File: tb/tb_anc_adapt.sv
// ---------------------------------------------------------------------------
// tb_anc_adapt
// Directed, table-driven bench for anc_adapt plus hand-written sequences for
// reset, latency, back-to-back throughput, enable drop and mid-flight reset.
// Inputs are driven on the falling edge, WzOut is checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_anc_adapt;
  import anc_pkg::*;

  logic Clk_100M;
  logic Reset;

  anc_adapt_if #(.DW(ANC_DW)) bus ();

  anc_adapt dut (
    .Clk_100M (Clk_100M),
    .Reset    (Reset),
    .bus      (bus)
  );

  initial Clk_100M = 1'b0;
  always #5 Clk_100M = ~Clk_100M;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string   name;
    sample_t err;
    sample_t sig;
    sample_t wz;
    sample_t exp_plain;
    sample_t exp_leaky;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input sample_t act, input sample_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: WzOut=%0d expected=%0d", name, act, exp);
    end else begin
      $display("ok   %s: WzOut=%0d", name, act);
    end
  endtask

  function automatic sample_t pick(input vec_t v);
`ifdef ANC_LEAKY_EN
    return v.exp_leaky;
`else
    return v.exp_plain;
`endif
  endfunction

  task automatic drive(input logic en, input sample_t e, input sample_t s, input sample_t w);
    bus.FilterEN = en;
    bus.Err      = e;
    bus.SigIn    = s;
    bus.WzIn     = w;
  endtask

  task automatic next_neg();
    @(negedge Clk_100M);
  endtask

  initial begin
    //              name          Err    SigIn  WzIn   plain  leaky
    vecs[0] = '{"basic",          10,    20,    100,   112,   112};
    vecs[1] = '{"floor_neg",      -1,    1,     0,     -1,    -1};
    vecs[2] = '{"floor_pos",      1,     1,     0,     0,     0};
    vecs[3] = '{"sat_pos",        1023,  1023,  1023,  1023,  1023};
    vecs[4] = '{"sat_neg",        -1024, 1023,  -1024, -1024, -1024};
    vecs[5] = '{"min_x_min",      -1024, -1024, 0,     1023,  1023};
    vecs[6] = '{"leak_only",      0,     0,     512,   512,   510};
    vecs[7] = '{"neg_mix",        100,   -50,   -300,  -613,  -611};
    vecs[8] = '{"big_prod",       1023,  1023,  0,     1023,  1023};
    vecs[9] = '{"small_neg",      -7,    3,     5,     3,     3};

    // Reset held low with live inputs: WzOut stays 0.
    Reset = 1'b0;
    drive(1'b1, 10, 20, 0);
    for (int i = 0; i < 3; i++) begin
      next_neg();
      check($sformatf("reset_hold%0d", i), bus.WzOut, 0);
    end
    // Release with FilterEN low: nothing enters, WzOut stays 0.
    bus.FilterEN = 1'b0;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_neg();
      check($sformatf("release_idle%0d", i), bus.WzOut, 0);
    end

    // Held input: one cycle after the first enabled edge still 0, then 112.
    drive(1'b1, 10, 20, 100);
    next_neg();
    check("latency_edgeN", bus.WzOut, 0);
    for (int i = 0; i < 9; i++) begin
      next_neg();
      check($sformatf("hold112_%0d", i), bus.WzOut, 112);
    end

    // Table vectors: each held two edges, checked after the second.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].err, vecs[i].sig, vecs[i].wz);
      next_neg();
      next_neg();
      check(vecs[i].name, bus.WzOut, pick(vecs[i]));
    end

    // Back-to-back: a new sample every cycle, one result per cycle.
    drive(1'b1, 10, 20, 100);
    next_neg();
    drive(1'b1, -1, 1, 0);
    next_neg();
    check("b2b_0", bus.WzOut, 112);
    drive(1'b1, 1, 1, 0);
    next_neg();
    check("b2b_1", bus.WzOut, -1);
    drive(1'b1, -7, 3, 5);
    next_neg();
    check("b2b_2", bus.WzOut, 0);
    bus.FilterEN = 1'b0;
    next_neg();
    check("b2b_3", bus.WzOut, 3);

    // Single-cycle enable pulse: the in-flight sample completes, then holds.
    drive(1'b1, 1, 1, 0);
    next_neg();
    next_neg();
    check("pulse_pre", bus.WzOut, 0);
    drive(1'b1, 10, 20, 100);
    next_neg();
    drive(1'b0, 10, 20, 0);
    for (int i = 0; i < 4; i++) begin
      next_neg();
      check($sformatf("pulse_hold%0d", i), bus.WzOut, 112);
    end

    // Reset between the two edges of a sample: the sample is discarded.
    drive(1'b1, -1, 1, 0);
    next_neg();
    #2 Reset = 1'b0;
    #1 check("midrst_async", bus.WzOut, 0);
    bus.FilterEN = 1'b0;
    #1 Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_neg();
      check($sformatf("midrst_drop%0d", i), bus.WzOut, 0);
    end

    // Recovery needs a fresh enabled sample.
    drive(1'b1, 10, 20, 100);
    next_neg();
    check("recover_lat", bus.WzOut, 0);
    next_neg();
    check("recover", bus.WzOut, 112);
    bus.FilterEN = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
